// File: rtl/text_overlay_sequencer.sv
// text_overlay_sequencer
// Per-scanline glyph prefetch for the on-screen text band. On each line_start
// that falls inside the band, the sequencer walks every character slot, reads
// one glyph row per slot from the shared font ROM into a back buffer, then
// commits the whole row to the display buffer that text_on reads per pixel.
// Optional feature macro: SCORE_COUNTER_EN adds an internal 4-digit BCD score
// counter whose digits replace the last four character slots.
module text_overlay_sequencer #(
  parameter int TEXT_X    = 500,
  parameter int TEXT_Y    = 100,
  parameter int NUM_CHARS = 8,
  parameter int ROW_H     = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  input  logic [9:0]  DrawX,
  input  logic        char_we,
  input  logic [3:0]  char_idx,
  input  logic [7:0]  char_code,
  input  logic        score_inc,
  input  logic        score_clr,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        busy,
  output logic        text_on,
  output logic [15:0] score_bcd
);
  localparam int SLOT_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int ROW_W  = (ROW_H > 1) ? $clog2(ROW_H) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHARS - 1);
`ifdef SCORE_COUNTER_EN
  localparam int WRITABLE = NUM_CHARS - 4;  // score digits own the last four slots
`else
  localparam int WRITABLE = NUM_CHARS;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_COMMIT} state_t;

  state_t            state_reg, state_next;
  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              line_valid_reg;
  logic              clear_valid;
  logic              in_band;
  logic              cap_en;
  logic [SLOT_W-1:0] cap_idx;
  logic [7:0]        char_reg    [NUM_CHARS];
  logic [7:0]        back_reg    [NUM_CHARS];
  logic [7:0]        display_reg [NUM_CHARS];
  logic [7:0]        slot_code   [NUM_CHARS];
  logic [15:0]       score_reg;
  logic [9:0]        rel_x;
  logic [7:0]        pix_byte;

  assign in_band = (next_line >= 10'(TEXT_Y)) && (next_line <= 10'(TEXT_Y + ROW_H - 1));

  // State register, fetch slot counter and latched glyph row
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      slot_reg  <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      row_reg   <= row_next;
    end
  end

  // Next state and outputs; a line_start in any state restarts the sequence
  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    row_next    = row_reg;
    clear_valid = 1'b0;
    busy        = 1'b0;
    rom_addr    = '0;
    cap_en      = 1'b0;
    cap_idx     = LAST_SLOT;
    if (line_start) begin
      row_next  = ROW_W'(next_line - 10'(TEXT_Y));
      slot_next = '0;
      if (in_band) begin
        state_next = S_FETCH;
      end else begin
        state_next  = S_IDLE;
        clear_valid = 1'b1;
      end
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (slot_reg == LAST_SLOT) state_next = S_DRAIN;
          else                       slot_next  = slot_reg + SLOT_W'(1);
        end
        S_DRAIN:  state_next = S_COMMIT;
        S_COMMIT: state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
    case (state_reg)
      S_FETCH: begin
        busy     = 1'b1;
        // 11-bit address arithmetic wraps for codes above 127
        rom_addr = 11'(slot_code[slot_reg]) * 11'(ROW_H) + 11'(row_reg);
        // ROM data lags the address by one cycle, so it belongs to the previous slot
        if (slot_reg != '0) begin
          cap_en  = 1'b1;
          cap_idx = slot_reg - SLOT_W'(1);
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        cap_en  = 1'b1;
        cap_idx = LAST_SLOT;
      end
      default: ;
    endcase
  end

  // Back buffer capture, commit to the display buffer and line validity
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        back_reg[i]    <= '0;
        display_reg[i] <= '0;
      end
      line_valid_reg <= 1'b0;
    end else begin
      if (cap_en) back_reg[cap_idx] <= rom_data;
      if (state_reg == S_COMMIT) begin
        for (int i = 0; i < NUM_CHARS; i++) display_reg[i] <= back_reg[i];
      end
      if (clear_valid)                 line_valid_reg <= 1'b0;
      else if (state_reg == S_COMMIT)  line_valid_reg <= 1'b1;
    end
  end

  // Character registers; a same-cycle fetch still reads the old code
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CHARS; i++) char_reg[i] <= 8'h20;
    end else if (char_we && (int'(char_idx) < WRITABLE)) begin
      char_reg[char_idx[SLOT_W-1:0]] <= char_code;
    end
  end

  // Per-slot code source: character register or ASCII score digit
  for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_code
`ifdef SCORE_COUNTER_EN
    if (gi >= NUM_CHARS - 4) begin : g_digit
      assign slot_code[gi] = 8'h30 + {4'h0, score_reg[4*(NUM_CHARS-1-gi) +: 4]};
    end else begin : g_char
      assign slot_code[gi] = char_reg[gi];
    end
`else
    assign slot_code[gi] = char_reg[gi];
`endif
  end

`ifdef SCORE_COUNTER_EN
  logic [15:0] score_next;
  logic        carry;

  // BCD increment with ripple carry; clear has priority
  always_comb begin
    score_next = score_reg;
    carry      = 1'b1;
    if (score_clr) begin
      score_next = '0;
    end else if (score_inc) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (score_reg[4*d +: 4] == 4'd9) begin
            score_next[4*d +: 4] = 4'd0;
          end else begin
            score_next[4*d +: 4] = score_reg[4*d +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Score register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) score_reg <= '0;
    else       score_reg <= score_next;
  end
`else
  logic unused_score;
  assign unused_score = score_inc ^ score_clr;
  assign score_reg    = '0;
`endif

  assign score_bcd = score_reg;

  // A pixel left of the band wraps rel_x far above the band width (10-bit DrawX)
  assign rel_x    = DrawX - 10'(TEXT_X);
  assign pix_byte = display_reg[rel_x[SLOT_W+2:3]];
  assign text_on  = line_valid_reg && (rel_x < 10'(8 * NUM_CHARS)) &&
                    pix_byte[3'd7 - rel_x[2:0]];

endmodule

// File: tb/tb_text_overlay_sequencer.sv
// Testbench for text_overlay_sequencer: registered font ROM stand-in, a
// behavioural model of the character slots, score and committed display row,
// directed and randomized line fetches. Score checks follow SCORE_COUNTER_EN.
module tb_text_overlay_sequencer;
  localparam int TEXT_X = 500;
  localparam int TEXT_Y = 100;
  localparam int N      = 8;
  localparam int ROW_H  = 16;
`ifdef SCORE_COUNTER_EN
  localparam int WRITABLE = N - 4;
`else
  localparam int WRITABLE = N;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  next_line = '0;
  logic [9:0]  DrawX = '0;
  logic        char_we = 1'b0;
  logic [3:0]  char_idx = '0;
  logic [7:0]  char_code = '0;
  logic        score_inc = 1'b0;
  logic        score_clr = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        busy;
  logic        text_on;
  logic [15:0] score_bcd;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_chars [N];
  logic [7:0] m_disp  [N];
  logic [7:0] fetched [N];
  logic       m_valid;
  int         m_score;

  text_overlay_sequencer dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .next_line(next_line),
    .DrawX(DrawX), .char_we(char_we), .char_idx(char_idx), .char_code(char_code),
    .score_inc(score_inc), .score_clr(score_clr), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .text_on(text_on), .score_bcd(score_bcd)
  );

  always #100 Clk = ~Clk;

  function automatic logic [7:0] font(input logic [10:0] a);
    return 8'((int'(a) * 73 + 19) ^ (int'(a) >> 3));
  endfunction

  always @(posedge Clk) rom_data <= font(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_chars[i] = 8'h20;
      m_disp[i]  = 8'h00;
    end
    m_valid = 1'b0;
    m_score = 0;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] model_code(input int s);
`ifdef SCORE_COUNTER_EN
    int p;
    p = 1;
    if (s >= N - 4) begin
      for (int i = 0; i < N - 1 - s; i++) p = p * 10;
      return 8'(8'h30 + (m_score / p) % 10);
    end
`endif
    return m_chars[s];
  endfunction

  function automatic logic exp_text_on(input int x);
    int rel;
    if (!m_valid) return 1'b0;
    if (x < TEXT_X || x > TEXT_X + 8 * N - 1) return 1'b0;
    rel = x - TEXT_X;
    return m_disp[rel / 8][7 - rel % 8];
  endfunction

  task automatic sweep(input string tag);
    for (int x = TEXT_X - 12; x < TEXT_X + 8 * N + 12; x++) begin
      DrawX = 10'(x);
      #1;
      check($sformatf("%s@%0d", tag, x), 32'(text_on), 32'(exp_text_on(x)));
    end
    DrawX = '0;
  endtask

  task automatic write_char(input int idx, input logic [7:0] code);
    char_we = 1'b1; char_idx = 4'(idx); char_code = code;
    tick();
    char_we = 1'b0;
    if (idx < WRITABLE) m_chars[idx] = code;
  endtask

  task automatic pulse_line(input int nl);
    line_start = 1'b1; next_line = 10'(nl);
    tick();
    line_start = 1'b0;
  endtask

  // Fetch phase after an in-band pulse_line; optional char write during slot wr_k
  task automatic fetch_body(input int row, input int wr_k, input int wr_idx, input logic [7:0] wr_code);
    for (int k = 0; k < N; k++) begin
      fetched[k] = model_code(k);
      check($sformatf("busy_fetch%0d", k), 32'(busy), 32'd1);
      check($sformatf("rom_addr_slot%0d", k), 32'(rom_addr),
            32'((int'(fetched[k]) * ROW_H + row) % 2048));
      if (k == wr_k) begin
        char_we = 1'b1; char_idx = 4'(wr_idx); char_code = wr_code;
      end
      tick();
      if (k == wr_k) begin
        char_we = 1'b0;
        if (wr_idx < WRITABLE) m_chars[wr_idx] = wr_code;
      end
    end
    check("busy_drain", 32'(busy), 32'd1);
    tick();
    check("busy_commit", 32'(busy), 32'd0);
    sweep("display_before_commit");
    tick();
    for (int s = 0; s < N; s++) m_disp[s] = font(11'((int'(fetched[s]) * ROW_H + row) % 2048));
    m_valid = 1'b1;
    check("busy_idle", 32'(busy), 32'd0);
    sweep("display_after_commit");
  endtask

  task automatic out_of_band(input int nl);
    pulse_line(nl);
    m_valid = 1'b0;
    check("busy_oob", 32'(busy), 32'd0);
    sweep("oob_text_on");
    tick();
    check("busy_oob_later", 32'(busy), 32'd0);
  endtask

  task automatic score_cycles(input logic inc, input logic clr, input int n);
    score_inc = inc; score_clr = clr;
    repeat (n) tick();
    score_inc = 1'b0; score_clr = 1'b0;
`ifdef SCORE_COUNTER_EN
    if (clr) m_score = 0;
    else if (inc) m_score = (m_score + n) % 10000;
`endif
  endtask

  initial begin
    int nl;
    model_reset();
    DrawX = 10'(TEXT_X + 1);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_text_on", 32'(text_on), 32'd0);
    check("reset_score", 32'(score_bcd), 32'd0);
    repeat (3) tick();
    Reset = 1'b0;
    tick();

    // Blank row 0 of all-space slots
    pulse_line(100);
    fetch_body(0, -1, 0, 8'h00);

    // "score" on row 3
    write_char(0, 8'h73); write_char(1, 8'h63); write_char(2, 8'h6F);
    write_char(3, 8'h72); write_char(4, 8'h65);
    pulse_line(103);
    check("rom_addr_s_row3", 32'(rom_addr), 32'h733);
    fetch_body(3, -1, 0, 8'h00);

    // Outside the band on both sides
    out_of_band(116);
    pulse_line(107);
    fetch_body(7, -1, 0, 8'h00);
    out_of_band(99);

    // Abort and restart: display keeps row 7 until the row 5 commit
    pulse_line(107);
    fetch_body(7, -1, 0, 8'h00);
    pulse_line(102);
    repeat (3) tick();
    sweep("display_held_during_abort");
    pulse_line(105);
    fetch_body(5, -1, 0, 8'h00);

    // Writes during fetch: same slot keeps old code, later slot uses new code
    pulse_line(109);
    fetch_body(9, 3, 3, 8'h41);
    pulse_line(110);
    fetch_body(10, 2, 6, 8'hC7);

    // Randomized writes and lines
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 3; w++) write_char(int'($urandom_range(0, 15)), 8'($urandom));
      nl = int'($urandom_range(96, 120));
      if (nl >= TEXT_Y && nl <= TEXT_Y + ROW_H - 1) begin
        pulse_line(nl);
        fetch_body(nl - TEXT_Y, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)), 8'($urandom));
      end else begin
        out_of_band(nl);
      end
    end

    // Score counter (tied to zero when the feature is absent)
    score_cycles(1'b1, 1'b0, 10000);
    check("score_wrap", 32'(score_bcd), 32'(to_bcd(m_score)));
    score_cycles(1'b1, 1'b0, 42);
    check("score_42", 32'(score_bcd), 32'(to_bcd(m_score)));
`ifdef SCORE_COUNTER_EN
    check("score_42_const", 32'(score_bcd), 32'h0042);
`else
    check("score_tied_zero", 32'(score_bcd), 32'h0000);
`endif
    pulse_line(104);
    fetch_body(4, 1, 5, 8'h58);
    score_cycles(1'b1, 1'b1, 1);
    check("score_clr_wins", 32'(score_bcd), 32'(to_bcd(m_score)));

    // Asynchronous reset in the middle of a fetch
    write_char(0, 8'h41);
    pulse_line(101);
    tick(); tick();
    DrawX = 10'(TEXT_X + 2);
    #20;
    Reset = 1'b1;
    #1;
    model_reset();
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rom_addr", 32'(rom_addr), 32'd0);
    check("midreset_text_on", 32'(text_on), 32'd0);
    check("midreset_score", 32'(score_bcd), 32'd0);
    @(posedge Clk);
    #30;
    Reset = 1'b0;
    tick();
    pulse_line(100);
    check("post_reset_space_code", 32'(rom_addr), 32'h200);
    fetch_body(0, -1, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
